program_loader: RTL

- Boot-time instruction loader that sits directly upstream of the CPU core's instruction memory (the program_counter ROM).
- Consumes a byte stream from a serial receiver and assembles 16-bit instruction words.
- Issues write strobes into instruction memory.
- Holds the core halted while a program is being loaded and releases it only after the frame checksum verifies.

---
 rtl/program_loader_if.sv | 31 +++
 rtl/program_loader.sv | 123 ++++++++++++
 2 files changed

// File: rtl/program_loader_if.sv
// Bus bundle between the serial byte source, the program loader and the
// instruction memory / core control.
//   i_rx_valid, i_rx_data : received byte strobe and value (source -> loader)
//   o_wr_en, o_wr_addr,
//   o_wr_data             : instruction memory write port (loader -> memory)
//   o_hold                : core halt request
//   o_done                : one-cycle pulse on a verified frame
//   o_error               : sticky checksum / timeout error
// master drives the byte stream and observes the loader; slave is the loader.
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  i_rx_valid;
  logic [7:0]            i_rx_data;
  logic                  o_wr_en;
  logic [ADDR_WIDTH-1:0] o_wr_addr;
  logic [15:0]           o_wr_data;
  logic                  o_hold;
  logic                  o_done;
  logic                  o_error;

  modport master (
    output i_rx_valid, i_rx_data,
    input  o_wr_en, o_wr_addr, o_wr_data, o_hold, o_done, o_error
  );

  modport slave (
    input  i_rx_valid, i_rx_data,
    output o_wr_en, o_wr_addr, o_wr_data, o_hold, o_done, o_error
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time instruction loader. Parses frames of the form
//   0xA5, LEN, LEN x {hi, lo}, CHK
// from a byte stream, writes each 16-bit word into instruction memory at
// consecutive addresses starting from 0, and holds the core halted until the
// frame checksum (mod-256 sum of the data bytes) verifies.
// Ports:
//   i_clk   : clock, rising edge
//   i_rst_n : asynchronous active-low reset
//   bus     : program_loader_if.slave (byte input, memory write port,
//             o_hold / o_done / o_error status)
module program_loader #(
  parameter int unsigned ADDR_WIDTH     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter bit          BOOT_HOLD      = 1'b0
) (
  input logic             i_clk,
  input logic             i_rst_n,
  program_loader_if.slave bus
);

  localparam int unsigned TmoW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [7:0]  Header = 8'hA5;

  typedef enum logic [2:0] {StIdle, StLen, StDataHi, StDataLo, StCheck} state_e;

  state_e                state_q;
  logic [7:0]            hi_q;
  logic [7:0]            acc_q;
  logic [8:0]            words_q;  // 9 bits so LEN=0 can mean 256
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [TmoW-1:0]       tmo_q;
  logic                  wr_en_q;
  logic [ADDR_WIDTH-1:0] wr_addr_q;
  logic [15:0]           wr_data_q;
  logic                  hold_q;
  logic                  done_q;
  logic                  error_q;
  logic                  expire;

  // Expiry only counts when no byte arrives; a byte on the expiry cycle wins.
  assign expire = (state_q != StIdle) && !bus.i_rx_valid &&
                  (tmo_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      hi_q      <= '0;
      acc_q     <= '0;
      words_q   <= '0;
      addr_q    <= '0;
      tmo_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      hold_q    <= BOOT_HOLD;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      wr_en_q <= 1'b0;
      done_q  <= 1'b0;

      if (state_q == StIdle || bus.i_rx_valid || expire) begin
        tmo_q <= '0;
      end else begin
        tmo_q <= tmo_q + TmoW'(1);
      end

      if (bus.i_rx_valid) begin
        unique case (state_q)
          StIdle: begin
            if (bus.i_rx_data == Header) begin
              state_q <= StLen;
              hold_q  <= 1'b1;
              error_q <= 1'b0;
              acc_q   <= '0;
              addr_q  <= '0;
            end
          end
          StLen: begin
            words_q <= {(bus.i_rx_data == 8'h00), bus.i_rx_data};
            state_q <= StDataHi;
          end
          StDataHi: begin
            hi_q    <= bus.i_rx_data;
            acc_q   <= acc_q + bus.i_rx_data;
            state_q <= StDataLo;
          end
          StDataLo: begin
            acc_q     <= acc_q + bus.i_rx_data;
            wr_en_q   <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= {hi_q, bus.i_rx_data};
            addr_q    <= addr_q + ADDR_WIDTH'(1);
            words_q   <= words_q - 9'd1;
            state_q   <= (words_q == 9'd1) ? StCheck : StDataHi;
          end
          StCheck: begin
            if (bus.i_rx_data == acc_q) begin
              done_q <= 1'b1;
              hold_q <= 1'b0;
            end else begin
              // Memory is partially overwritten: keep the core halted.
              error_q <= 1'b1;
            end
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end else if (expire) begin
        error_q <= 1'b1;
        state_q <= StIdle;
      end
    end
  end

  assign bus.o_wr_en   = wr_en_q;
  assign bus.o_wr_addr = wr_addr_q;
  assign bus.o_wr_data = wr_data_q;
  assign bus.o_hold    = hold_q;
  assign bus.o_done    = done_q;
  assign bus.o_error   = error_q;

endmodule
